// File: rtl/sdram_init_refresh.sv
// SDRAM power-up initialisation sequencer and periodic auto-refresh scheduler.
// Owns the command pins until init completes, then borrows them per refresh grant.
module sdram_init_refresh #(
  parameter int unsigned INIT_WAIT    = 5000,
  parameter int unsigned T_RP         = 2,
  parameter int unsigned T_RC         = 4,
  parameter int unsigned T_MRD        = 2,
  parameter int unsigned REF_INTERVAL = 390,
  parameter logic [12:0] MODE_REG     = 13'h0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ref_ack,
  output logic        init_done,
  output logic        ref_req,
  output logic        bus_own,
  output logic        cmd_cke,
  output logic        cmd_cs_n,
  output logic        cmd_ras_n,
  output logic        cmd_cas_n,
  output logic        cmd_we_n,
  output logic [12:0] cmd_addr,
  output logic [1:0]  cmd_ba
);

  localparam int CW = $clog2(INIT_WAIT + T_RP + T_RC + T_MRD + 1);
  localparam int IW = $clog2(REF_INTERVAL + 1);

  // Wait states count down from T-2 so the command plus its NOPs span T cycles.
  localparam logic [CW-1:0] RP_LOAD   = CW'(T_RP - 2);
  localparam logic [CW-1:0] RC_LOAD   = CW'(T_RC - 2);
  localparam logic [CW-1:0] MRD_LOAD  = CW'(T_MRD - 2);
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_WAIT);
  localparam logic [IW-1:0] IVL_LAST  = IW'(REF_INTERVAL - 1);

  localparam logic [3:0] S_WAIT   = 4'd0;
  localparam logic [3:0] S_PRE    = 4'd1;
  localparam logic [3:0] S_PRE_W  = 4'd2;
  localparam logic [3:0] S_REF1   = 4'd3;
  localparam logic [3:0] S_REF1_W = 4'd4;
  localparam logic [3:0] S_REF2   = 4'd5;
  localparam logic [3:0] S_REF2_W = 4'd6;
  localparam logic [3:0] S_MRS    = 4'd7;
  localparam logic [3:0] S_MRS_W  = 4'd8;
  localparam logic [3:0] S_RUN    = 4'd9;
  localparam logic [3:0] S_AREF   = 4'd10;
  localparam logic [3:0] S_AREF_W = 4'd11;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_INH = 4'b1111;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  logic [3:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [IW-1:0] icnt, icnt_d;
  logic [2:0]    owed, owed_d;
  logic          ack_q, ack_q_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [12:0]   addr_d;
  logic          bus_own_d, init_done_d, ref_req_d;
  logic          run_phase, tick, dec;

  assign {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n} = cmd_q;

  assign run_phase = (state == S_RUN) || (state == S_AREF) || (state == S_AREF_W);
  assign tick      = run_phase && (icnt == IVL_LAST);
  assign dec       = (state == S_RUN) && ack_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state;
    cnt_d       = cnt;
    cmd_d       = CMD_NOP;
    addr_d      = '0;
    bus_own_d   = 1'b1;
    init_done_d = init_done;
    unique case (state)
      S_WAIT: begin
        if (cnt == INIT_LAST) begin
          state_d    = S_PRE;
          cmd_d      = CMD_PRE;
          addr_d[10] = 1'b1;
          cnt_d      = RP_LOAD;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_PRE:  state_d = S_PRE_W;
      S_PRE_W: begin
        if (cnt == '0) begin
          state_d = S_REF1;
          cmd_d   = CMD_REF;
          cnt_d   = RC_LOAD;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_REF1: state_d = S_REF1_W;
      S_REF1_W: begin
        if (cnt == '0) begin
          state_d = S_REF2;
          cmd_d   = CMD_REF;
          cnt_d   = RC_LOAD;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_REF2: state_d = S_REF2_W;
      S_REF2_W: begin
        if (cnt == '0) begin
          state_d = S_MRS;
          cmd_d   = CMD_LMR;
          addr_d  = MODE_REG;
          cnt_d   = MRD_LOAD;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_MRS:  state_d = S_MRS_W;
      S_MRS_W: begin
        if (cnt == '0) begin
          state_d     = S_RUN;
          bus_own_d   = 1'b0;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_RUN: begin
        bus_own_d = 1'b0;
        if (ack_q) begin
          state_d   = S_AREF;
          cmd_d     = CMD_REF;
          bus_own_d = 1'b1;
          cnt_d     = RC_LOAD;
        end
      end
      S_AREF: state_d = S_AREF_W;
      S_AREF_W: begin
        if (cnt == '0) begin
          state_d   = S_RUN;
          bus_own_d = 1'b0;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Interval counter stays cleared until RUN is entered, then free-runs.
  always_comb begin
    icnt_d = '0;
    if (run_phase && !tick) icnt_d = icnt + 1'b1;
  end

  // A tick and a refresh on the same edge cancel out; owed saturates at 7.
  always_comb begin
    owed_d = owed;
    unique case ({tick, dec})
      2'b10:   owed_d = (owed == 3'd7) ? owed : owed + 3'd1;
      2'b01:   owed_d = owed - 3'd1;
      default: owed_d = owed;
    endcase
  end

  // The grant is latched for one cycle; the refresh command follows on the next edge.
  assign ack_q_d   = (state == S_RUN) && ref_req && ref_ack && !ack_q;
  assign ref_req_d = (state_d == S_RUN) && (owed_d != 3'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_WAIT;
      cnt       <= '0;
      icnt      <= '0;
      owed      <= '0;
      ack_q     <= 1'b0;
      cmd_q     <= CMD_INH;
      cmd_cke   <= 1'b0;
      cmd_addr  <= '0;
      cmd_ba    <= '0;
      bus_own   <= 1'b1;
      init_done <= 1'b0;
      ref_req   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_d;
      cnt       <= cnt_d;
      icnt      <= icnt_d;
      owed      <= owed_d;
      ack_q     <= ack_q_d;
      cmd_q     <= cmd_d;
      cmd_cke   <= 1'b1;
      cmd_addr  <= addr_d;
      cmd_ba    <= 2'b00;
      bus_own   <= bus_own_d;
      init_done <= init_done_d;
      ref_req   <= ref_req_d;
    end
  end

endmodule

// File: doc/sdram_init_refresh.md
# sdram_init_refresh

Power-up initialisation sequencer and periodic auto-refresh scheduler for the board SDRAM (16-bit, 4 banks, 13-bit row address). After reset it owns the SDRAM command pins, waits the 100 µs power-up period, then issues PRECHARGE ALL, two AUTO REFRESH commands and LOAD MODE REGISTER. It then hands the pins back to `mem_ctl` and raises refresh requests at a fixed interval. `mem_ctl` grants each request, and during the grant this block drives one AUTO REFRESH. `mem_ctl` muxes the SDRAM pins to this block whenever `bus_own` is high.

## Interface

Parameters:
- `INIT_WAIT`, 5000: power-up wait in cycles (100 µs at 50 MHz).
- `T_RP`, 2: cycles from PRECHARGE to the next command.
- `T_RC`, 4: cycles from AUTO REFRESH to the next command.
- `T_MRD`, 2: cycles from LOAD MODE to the next command or to hand-off.
- `REF_INTERVAL`, 390: cycles between refresh ticks (7.8 µs at 50 MHz).
- `MODE_REG`, 13'h0020: mode word (CAS latency 2, sequential, burst length 1).

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `ref_ack`, in, 1: one-cycle grant from `mem_ctl`. The bus is idle and this block may take it.
- `init_done`, out, 1: initialisation complete. Stays high until the next reset.
- `ref_req`, out, 1: one or more refreshes are owed.
- `bus_own`, out, 1: this block is driving the SDRAM command pins.
- `cmd_cke`, out, 1: clock enable.
- `cmd_cs_n`, out, 1: chip select, active-low.
- `cmd_ras_n`, out, 1: row address strobe, active-low.
- `cmd_cas_n`, out, 1: column address strobe, active-low.
- `cmd_we_n`, out, 1: write enable, active-low.
- `cmd_addr`, out, 13: SDRAM address pins.
- `cmd_ba`, out, 2: bank address pins.

## Operation

- All outputs are registered. Commands use {cs_n, ras_n, cas_n, we_n}:
  - NOP = 0111
  - PRECHARGE = 0010, with `cmd_addr[10]`=1
  - AUTO REFRESH = 0001
  - LOAD MODE = 0000, with `cmd_addr`=`MODE_REG` and `cmd_ba`=0
- Every command lasts exactly one cycle. NOPs fill all other cycles while `bus_own`=1. `cmd_addr` and `cmd_ba` are 0 on all cycles other than PRECHARGE and LOAD MODE.
- States:
  - WAIT (count `INIT_WAIT`) → PRE → PRE_W (`T_RP`−1 NOPs) → REF1 → REF1_W (`T_RC`−1) → REF2 → REF2_W (`T_RC`−1) → MRS → MRS_W (`T_MRD`−1) → RUN.
  - In RUN: an accepted grant goes to AREF, then AREF_W (`T_RC`−1), then back to RUN.
- Entering RUN sets `init_done`=1 and `bus_own`=0, and clears and starts the interval counter.
- Interval counter:
  - Runs in every state from RUN onward, including AREF and AREF_W.
  - Each time it reaches `REF_INTERVAL` it wraps to 0 and increments the `owed` counter (3 bits, saturating at 7).
- `ref_req` = (`owed` ≠ 0) while in RUN. It is 0 during AREF and AREF_W and throughout initialisation.
- `ref_ack` is honoured only when in RUN with `ref_req`=1. At all other times it is ignored.
- On AREF entry, `owed` decrements. If a tick lands on the same edge, `owed` holds its value (net zero).
- Reset asserted at any time, including mid-initialisation or mid-refresh: all outputs go immediately to their reset values, and the full initialisation sequence restarts.

## Timing

- Reset values:
  - `cmd_cke`=0
  - `cmd_cs_n`, `cmd_ras_n`, `cmd_cas_n`, `cmd_we_n` all 1 (INHIBIT)
  - `cmd_addr`=0, `cmd_ba`=0
  - `bus_own`=1, `init_done`=0, `ref_req`=0
- Edge 1 is the first rising edge after `rst` deasserts. At edge 1, `cmd_cke`=1 and the command becomes NOP.
- Command edges with default parameters:
  - PRECHARGE at edge `INIT_WAIT`+1 = 5001
  - REF1 at 5001+`T_RP` = 5003
  - REF2 at 5003+`T_RC` = 5007
  - LOAD MODE at 5011
  - `init_done`↑ and `bus_own`↓ at 5011+`T_MRD` = 5013
- First `ref_req`↑ at edge 5013+`REF_INTERVAL` = 5403.
- Refresh handshake:
  - `ref_ack`=1 sampled at edge E.
  - At E+1: AUTO REFRESH is on the pins, `bus_own`=1, `ref_req`=0.
  - At E+1+`T_RC`: `bus_own`=0. `ref_req` returns high if `owed` ≠ 0.
- `mem_ctl` must not drive the pins from E+1 until `bus_own` falls.

## Test plan

- Reset release → outputs hold their reset values through edge 0. `cmd_cke`=1 at edge 1. PRECHARGE with `cmd_addr`=0x400 at 5001, AUTO REFRESH at 5003 and 5007, LOAD MODE with `cmd_addr`=0x020 at 5011, `init_done`=1 and `bus_own`=0 at 5013.
- Idle after init with `ref_ack` tied 0 → `ref_req`↑ at 5403. `owed` reaches 7 after 7 intervals and stays at 7. Then 7 single-cycle acks, each spaced 6 cycles apart, produce exactly 7 AUTO REFRESH commands, and `ref_req` ends at 0.
- `ref_ack` pulsed at edge 5410 with `ref_req`=1 → AUTO REFRESH at 5411, `bus_own`=1 for edges 5411–5414, `bus_own`=0 at 5415.
- `ref_ack` pulsed at 2000 (during init), and again during AREF_W → ignored: no extra command, `owed` unchanged.
- Interval tick on the same edge as AREF entry with `owed`=1 → `owed` stays 1, and `ref_req`=1 again after `bus_own` falls.
- `rst` asserted at edge 5005, between REF1 and REF2 → outputs are asynchronously at reset values before the next edge. After release, the full sequence repeats with PRECHARGE at edge 5001 relative to the new release.
